// File: rtl/mul_seq_pkg.sv
// Shared constants and types for the nibble-serial 8x8 multiply sequencer.
package mul_seq_pkg;
  localparam int CORE_W = 4;
  localparam int OP_W   = 2 * CORE_W;
  localparam int P_W    = 2 * OP_W;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef logic [1:0] step_t;

  // Shift applied to each nibble partial product, indexed by step.
  function automatic logic [3:0] shift_of(step_t s);
    case (s)
      2'd0:    shift_of = 4'd0;
      2'd1:    shift_of = 4'd4;
      2'd2:    shift_of = 4'd4;
      default: shift_of = 4'd8;
    endcase
  endfunction
endpackage

// File: rtl/mul_seq_acc.sv
// 16-bit shift-add accumulator for nibble partial products.
module mul_seq_acc
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [OP_W-1:0]   addend,
  input  logic [3:0]        shift,
  output logic [P_W-1:0]    acc
);
  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= acc + (P_W'(addend) << shift);
  end
endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequences an 8x8 unsigned multiply through an external 4x4 core over four cycles.
module mul8_seq_ctrl
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [P_W-1:0]    out_p,
  output logic [CORE_W-1:0] core_x,
  output logic [CORE_W-1:0] core_y,
  input  logic [OP_W-1:0]   core_o,
  output logic              busy
);
  state_t            state;
  step_t             step;
  logic [OP_W-1:0]   a_r;
  logic [OP_W-1:0]   b_r;
  logic              accept;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= in_a;
            b_r   <= in_b;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (step == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core inputs come only from registered state so the core never sees handshake glitches.
  always_comb begin
    core_x = '0;
    core_y = '0;
    if (state == MUL) begin
      core_x = step[0] ? a_r[OP_W-1:CORE_W] : a_r[CORE_W-1:0];
      core_y = step[1] ? b_r[OP_W-1:CORE_W] : b_r[CORE_W-1:0];
    end
  end

  mul_seq_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (state == MUL),
    .addend (core_o),
    .shift  (shift_of(step)),
    .acc    (out_p)
  );
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and streaming checks of mul8_seq_ctrl against a behavioural 4x4 core and a product scoreboard.
module tb_mul8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_p;
  logic [3:0]  core_x;
  logic [3:0]  core_y;
  logic [7:0]  core_o;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -1;
  int out_count = 0;
  bit stream_on = 1'b0;
  logic [15:0] sb[$];

  assign core_o = core_x * core_y;

  mul8_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .core_x(core_x), .core_y(core_y), .core_o(core_o), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle; inputs only move just after the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(16'(in_a) * 16'(in_b));
        if (stream_on && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 6);
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else chk("scoreboard_out_p", out_p, sb.pop_front());
      end
    end
  end

  task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("wait_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("wait_out_valid", out_valid, 1);
  endtask

  logic [3:0] ex_x[4] = '{4'h5, 4'hA, 4'h5, 4'hA};
  logic [3:0] ex_y[4] = '{4'hC, 4'hC, 4'h3, 4'h3};
  logic [7:0] ex_o[4] = '{8'h3C, 8'h78, 8'h0F, 8'h1E};

  initial begin
    int n;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_core_x", core_x, 0);

    // 1) 0xA5 * 0x3C with per-step core traffic
    accept_op(8'hA5, 8'h3C);
    for (int k = 0; k < 4; k++) begin
      chk("t1_core_x", core_x, ex_x[k]);
      chk("t1_core_y", core_y, ex_y[k]);
      chk("t1_core_o", core_o, ex_o[k]);
      chk("t1_out_valid_low", out_valid, 0);
      chk("t1_in_ready_low", in_ready, 0);
      tick();
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_p", out_p, 16'h26AC);
    chk("t1_done_core_x", core_x, 0);
    tick();
    chk("t1_idle_in_ready", in_ready, 1);
    chk("t1_idle_out_valid", out_valid, 0);

    // 2) extremes
    accept_op(8'hFF, 8'hFF);
    wait_out(n);
    chk("t2_max", out_p, 16'hFE01);
    tick();
    accept_op(8'h00, 8'hFF);
    wait_out(n);
    chk("t2_zero_latency", n, 4);
    chk("t2_zero", out_p, 16'h0000);
    tick();

    // 3) output backpressure
    out_ready = 1'b0;
    accept_op(8'h12, 8'h34);
    wait_out(n);
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_p", out_p, 16'h03A8);
      chk("t3_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_release_in_ready", in_ready, 1);
    chk("t3_release_out_valid", out_valid, 0);

    // 4) reset in step 2 abandons the product
    accept_op(8'h77, 8'h99);
    tick(); tick();
    chk("t4_busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    chk("t4_rst_in_ready", in_ready, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_out_valid", out_valid, 0);
    chk("t4_rst_out_p", out_p, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t4_no_output", out_valid, 0);
      tick();
    end
    accept_op(8'h03, 8'h05);
    wait_out(n);
    chk("t4_next_op", out_p, 16'h000F);
    tick();

    // 5) back-to-back stream
    out_count = 0;
    last_acc = -1;
    stream_on = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_a = 8'($urandom_range(0, 255));
      in_b = 8'($urandom_range(0, 255));
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      chk("t5_wait_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    stream_on = 1'b0;
    n = 0;
    while (out_count < 256 && n < 40) begin tick(); n++; end
    tick();
    chk("t5_out_count", out_count, 256);
    chk("t5_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
